// File: rtl/ks_pkg.sv
// ks_pkg -- shared helpers for the pipelined Kogge-Stone adder.
// rev 1.0
`default_nettype none

package ks_pkg;

  // Sideband bits that travel beside the (G,P) vectors: carry-in and x sign.
  localparam int KS_SIDE_EXTRA = 2;

  typedef enum logic {
    KS_EXACT  = 1'b0,
    KS_APPROX = 1'b1
  } ks_mode_e;

  function automatic int ks_levels(input int width);
    return $clog2(width);
  endfunction

  // Register j sits after prefix level round(j*(levels+1)/depth)-1.
  function automatic bit ks_reg_after(input int level, input int depth, input int levels);
    bit hit;
    hit = 1'b0;
    for (int j = 1; j < depth; j++) begin
      if ((2 * j * (levels + 1) + depth) / (2 * depth) == level + 1) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ks_prefix_level.sv
// ks_prefix_level -- one black-cell level of the Kogge-Stone tree, optionally registered.
// rev 1.0
`default_nettype none

module ks_prefix_level #(
  parameter int WIDTH      = 32,
  parameter int SPAN       = 1,
  parameter bit REGISTERED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             valid_i,
  input  logic             approx_i,
  input  logic             bypass_i,
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] p_i,
  output logic             valid_o,
  output logic             approx_o,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] p_o
);

  logic [WIDTH-1:0] g_d;
  logic [WIDTH-1:0] p_d;

  // Bits below SPAN have no lower neighbour: zeros shifted into G keep G,
  // ones shifted into P keep P.
  always_comb begin
    g_d = g_i;
    p_d = p_i;
    if (!bypass_i) begin
      g_d = g_i | (p_i & (g_i << SPAN));
      p_d = p_i & ~((~p_i) << SPAN);
    end
  end

  if (REGISTERED) begin : g_reg
    logic [WIDTH-1:0] g_q;
    logic [WIDTH-1:0] p_q;
    logic             valid_q;
    logic             approx_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        g_q      <= '0;
        p_q      <= '0;
        valid_q  <= 1'b0;
        approx_q <= 1'b0;
      end else if (adv) begin
        g_q      <= g_d;
        p_q      <= p_d;
        valid_q  <= valid_i;
        approx_q <= approx_i;
      end
    end

    assign g_o      = g_q;
    assign p_o      = p_q;
    assign valid_o  = valid_q;
    assign approx_o = approx_q;
  end else begin : g_comb
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, rst, adv};
    assign g_o      = g_d;
    assign p_o      = p_d;
    assign valid_o  = valid_i;
    assign approx_o = approx_i;
  end

endmodule

`default_nettype wire

// File: rtl/kogge_stone_pipe_adder.sv
// kogge_stone_pipe_adder -- pipelined Kogge-Stone adder with carry-in, flow control
// and a per-operation truncated-carry approximate mode. rev 1.0
`default_nettype none

module kogge_stone_pipe_adder
  import ks_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int PIPE_DEPTH = 2,
  parameter int APPROX_LVL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   s,
  output logic             ovf,
  output logic             approx_out
);

  localparam int LEVELS = ks_levels(WIDTH);
  localparam int SIDE_W = WIDTH + KS_SIDE_EXTRA;

  logic             adv;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic             cin_q;
  logic             approx_q;
  logic             valid_q;

  logic [WIDTH-1:0]  g_lv    [LEVELS+1];
  logic [WIDTH-1:0]  p_lv    [LEVELS+1];
  logic              v_lv    [LEVELS+1];
  logic              a_lv    [LEVELS+1];
  logic [SIDE_W-1:0] side_lv [LEVELS+1];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q      <= '0;
      y_q      <= '0;
      cin_q    <= 1'b0;
      approx_q <= 1'b0;
      valid_q  <= 1'b0;
    end else if (adv) begin
      x_q      <= x;
      y_q      <= y;
      cin_q    <= cin;
      approx_q <= approx_en;
      valid_q  <= in_valid;
    end
  end

  // cin is folded into bit 0 as g_-1, so G[i] after the tree is the carry into bit i+1.
  assign g_lv[0]    = {x_q[WIDTH-1:1] & y_q[WIDTH-1:1],
                       (x_q[0] & y_q[0]) | ((x_q[0] ^ y_q[0]) & cin_q)};
  assign p_lv[0]    = x_q ^ y_q;
  assign v_lv[0]    = valid_q;
  assign a_lv[0]    = approx_q;
  assign side_lv[0] = {cin_q, x_q[WIDTH-1], x_q ^ y_q};

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    localparam bit REG = ks_reg_after(k, PIPE_DEPTH, LEVELS);
    logic bypass;

    if (k >= APPROX_LVL) begin : g_trunc
      assign bypass = (ks_mode_e'(a_lv[k]) == KS_APPROX);
    end else begin : g_full
      assign bypass = 1'b0;
    end

    ks_prefix_level #(
      .WIDTH      (WIDTH),
      .SPAN       (1 << k),
      .REGISTERED (REG)
    ) u_level (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv),
      .valid_i  (v_lv[k]),
      .approx_i (a_lv[k]),
      .bypass_i (bypass),
      .g_i      (g_lv[k]),
      .p_i      (p_lv[k]),
      .valid_o  (v_lv[k+1]),
      .approx_o (a_lv[k+1]),
      .g_o      (g_lv[k+1]),
      .p_o      (p_lv[k+1])
    );

    if (REG) begin : g_side_reg
      logic [SIDE_W-1:0] side_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)     side_q <= '0;
        else if (adv) side_q <= side_lv[k];
      end
      assign side_lv[k+1] = side_q;
    end else begin : g_side_comb
      assign side_lv[k+1] = side_lv[k];
    end
  end

  logic [WIDTH-1:0] g_f;
  logic [WIDTH-1:0] p_f;
  logic             cin_f;
  logic             xs_f;

  assign g_f   = g_lv[LEVELS];
  assign p_f   = side_lv[LEVELS][WIDTH-1:0];
  assign xs_f  = side_lv[LEVELS][WIDTH];
  assign cin_f = side_lv[LEVELS][WIDTH+1];

  assign s          = {g_f[WIDTH-1], p_f ^ {g_f[WIDTH-2:0], cin_f}};
  assign ovf        = !p_f[WIDTH-1] && (s[WIDTH-1] != xs_f);
  assign out_valid  = v_lv[LEVELS];
  assign approx_out = a_lv[LEVELS];

endmodule

`default_nettype wire
